// File: rtl/lcd_msg_sequencer.sv
// Two-line LCD message sequencer: holds NUM_MSGS messages and presents them to
// an LCD controller in static, cycling or line-2 scrolling modes.
module lcd_msg_sequencer #(
  parameter int  NUM_MSGS      = 4,
  parameter int  DWELL_CYCLES  = 100_000_000,
  parameter int  SCROLL_CYCLES = 25_000_000,
  localparam int IW            = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1
) (
  input  logic          clk,
  input  logic          reset_btn,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [127:0]  wr_line1,
  input  logic [127:0]  wr_line2,
  input  logic [1:0]    mode,
  input  logic          start,
  input  logic          lcd_ready,
  output logic [127:0]  line1,
  output logic [127:0]  line2,
  output logic          refresh,
  output logic [IW-1:0] msg_idx,
  output logic          busy
);

  localparam logic [127:0]  BLANK        = {16{8'h20}};
  localparam logic [31:0]   DWELL_LIMIT  = 32'(DWELL_CYCLES);
  localparam logic [31:0]   SCROLL_LIMIT = 32'(SCROLL_CYCLES);
  localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_MSGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_REFRESH,
    S_DWELL
  } state_t;

  state_t          r_state;
  state_t          w_nextState;

  logic [1:0]      r_heldMode;
  logic [IW-1:0]   r_msgIdx;
  logic [3:0]      r_offset;
  logic [31:0]     r_dwellCnt;
  logic [127:0]    r_buf1 [NUM_MSGS];
  logic [127:0]    r_buf2 [NUM_MSGS];
  logic [127:0]    r_line1;
  logic [127:0]    r_line2;

  logic            w_wrOk;
  logic            w_cycleMode;
  logic            w_scrollMode;
  logic [31:0]     w_limit;
  logic            w_expired;
  logic [IW-1:0]   w_nextIdx;
  logic [255:0]    w_dbl;
  logic [7:0]      w_rotSel;
  logic [127:0]    w_rotLine2;

  // Mode values other than cycle and scroll (0 and 3) both behave as static.
  assign w_cycleMode  = (r_heldMode == 2'd1);
  assign w_scrollMode = (r_heldMode == 2'd2);
  assign w_limit      = w_scrollMode ? SCROLL_LIMIT : DWELL_LIMIT;
  assign w_expired    = (r_dwellCnt >= (w_limit - 32'd1));
  assign w_nextIdx    = (r_msgIdx == LAST_IDX) ? '0 : r_msgIdx + IW'(1);
  assign w_wrOk       = wr_en && ({{(32-IW){1'b0}}, wr_idx} < 32'(NUM_MSGS));

  // Doubling the line lets a single part-select implement the byte rotation.
  assign w_dbl      = {r_buf2[r_msgIdx], r_buf2[r_msgIdx]};
  assign w_rotSel   = 8'd255 - {1'b0, r_offset, 3'b000};
  assign w_rotLine2 = w_dbl[w_rotSel -: 128];

  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      for (int i = 0; i < NUM_MSGS; i++) begin
        r_buf1[i] <= BLANK;
        r_buf2[i] <= BLANK;
      end
    end else if (w_wrOk) begin
      r_buf1[wr_idx] <= wr_line1;
      r_buf2[wr_idx] <= wr_line2;
    end
  end

  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Start always wins, including over a dwell expiry in the same cycle.
  always_comb begin
    w_nextState = r_state;
    if (start) begin
      w_nextState = S_WAIT_RDY;
    end else begin
      case (r_state)
        S_IDLE:     w_nextState = S_IDLE;
        S_WAIT_RDY: if (lcd_ready) w_nextState = S_REFRESH;
        S_REFRESH:  w_nextState = lcd_ready ? S_DWELL : S_WAIT_RDY;
        S_DWELL: begin
          if (w_expired) begin
            w_nextState = (w_cycleMode || w_scrollMode) ? S_WAIT_RDY : S_IDLE;
          end
        end
        default:    w_nextState = S_IDLE;
      endcase
    end
  end

  // A refresh lost to a late lcd_ready drop is retried from WAIT_RDY.
  always_comb begin
    refresh = (r_state == S_REFRESH) && lcd_ready;
    busy    = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      r_heldMode <= 2'd0;
      r_msgIdx   <= '0;
      r_offset   <= 4'd0;
      r_dwellCnt <= 32'd0;
      r_line1    <= BLANK;
      r_line2    <= BLANK;
    end else if (start) begin
      r_heldMode <= mode;
      r_msgIdx   <= '0;
      r_offset   <= 4'd0;
    end else begin
      case (r_state)
        S_WAIT_RDY: begin
          if (lcd_ready) begin
            r_line1 <= r_buf1[r_msgIdx];
            r_line2 <= w_rotLine2;
          end
        end
        S_REFRESH: begin
          r_dwellCnt <= 32'd0;
        end
        S_DWELL: begin
          r_dwellCnt <= r_dwellCnt + 32'd1;
          if (w_expired) begin
            if (w_cycleMode) begin
              r_msgIdx <= w_nextIdx;
            end else if (w_scrollMode) begin
              r_offset <= r_offset + 4'd1;
              if (r_offset == 4'd15) r_msgIdx <= w_nextIdx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign line1   = r_line1;
  assign line2   = r_line2;
  assign msg_idx = r_msgIdx;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Scoreboard bench for lcd_msg_sequencer: expected frames are queued from a
// message-level model and popped by a monitor on every refresh pulse.
module tb_lcd_msg_sequencer;

  localparam int NUM_MSGS = 2;
  localparam int DWELL    = 10;
  localparam int SCROLL   = 4;
  localparam logic [127:0] BLANK = {16{8'h20}};

  logic         clk = 1'b0;
  logic         reset_btn;
  logic         wr_en;
  logic [0:0]   wr_idx;
  logic [127:0] wr_line1;
  logic [127:0] wr_line2;
  logic [1:0]   mode;
  logic         start;
  logic         lcd_ready;
  logic [127:0] line1;
  logic [127:0] line2;
  logic         refresh;
  logic [0:0]   msg_idx;
  logic         busy;

  lcd_msg_sequencer #(
    .NUM_MSGS      (NUM_MSGS),
    .DWELL_CYCLES  (DWELL),
    .SCROLL_CYCLES (SCROLL)
  ) dut (
    .clk       (clk),
    .reset_btn (reset_btn),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_line1  (wr_line1),
    .wr_line2  (wr_line2),
    .mode      (mode),
    .start     (start),
    .lcd_ready (lcd_ready),
    .line1     (line1),
    .line2     (line2),
    .refresh   (refresh),
    .msg_idx   (msg_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int           idx;
    logic [127:0] l1;
    logic [127:0] l2;
  } frame_t;

  frame_t       expQ[$];
  logic [127:0] m1 [NUM_MSGS];
  logic [127:0] m2 [NUM_MSGS];
  int           checks     = 0;
  int           failures   = 0;
  int           refCount   = 0;
  int           lastRefCyc = 0;
  logic         prevRefresh = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out waiting, got no event expected one", name);
  endtask

  // Message-level model: the displayed frame is the stored message with line 2
  // starting at character 'off' and wrapping around.
  function automatic frame_t model(input int idx, input int off);
    frame_t f;
    f.idx = idx;
    f.l1  = m1[idx];
    for (int i = 0; i < 16; i++) begin
      f.l2[127-8*i -: 8] = m2[idx][127-8*((i+off)%16) -: 8];
    end
    return f;
  endfunction

  function automatic logic [127:0] randLine();
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[8*i +: 8] = 8'($urandom_range(32, 126));
    return l;
  endfunction

  // Monitor: every refresh must consume exactly one queued frame.
  always @(negedge clk) begin
    frame_t e;
    if (reset_btn) begin
      if (refresh) begin
        refCount++;
        lastRefCyc = cyc;
        checkOutput("refresh_needs_ready", 128'(lcd_ready), 128'(1'b1));
        checkOutput("refresh_not_back_to_back", 128'(prevRefresh), 128'(1'b0));
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_refresh: got refresh idx=%0d expected none", msg_idx);
        end else begin
          e = expQ.pop_front();
          checkOutput("frame_line1", line1, e.l1);
          checkOutput("frame_line2", line2, e.l2);
          checkOutput("frame_idx", 128'(msg_idx), 128'(e.idx));
        end
      end
      prevRefresh = refresh;
    end else begin
      prevRefresh = 1'b0;
    end
  end

  task automatic writeSlot(input int idx, input logic [127:0] l1, input logic [127:0] l2);
    @(posedge clk); #1;
    wr_en    = 1'b1;
    wr_idx   = 1'(idx);
    wr_line1 = l1;
    wr_line2 = l2;
    @(posedge clk); #1;
    wr_en = 1'b0;
    m1[idx] = l1;
    m2[idx] = l2;
  endtask

  task automatic applyStimulus(input logic [1:0] m);
    @(posedge clk); #1;
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitRefresh(input int budget, output int at);
    int  c0 = refCount;
    bit  seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (refCount != c0) begin
        seen = 1'b1;
        break;
      end
    end
    at = lastRefCyc;
    if (!seen) reportTimeout("wait_refresh");
  endtask

  task automatic waitQueueEmpty(input int budget, input bit randReady);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (randReady) lcd_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk); #1;
      if (expQ.size() == 0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportTimeout("wait_queue_empty");
  endtask

  task automatic waitIdle(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportTimeout("wait_idle");
  endtask

  initial begin
    int           t0, t1, t, rise, c0;
    logic [127:0] oldL1, oldL2, nl1, nl2;

    reset_btn = 1'b1;
    wr_en     = 1'b0;
    wr_idx    = 1'b0;
    wr_line1  = '0;
    wr_line2  = '0;
    mode      = 2'd0;
    start     = 1'b0;
    lcd_ready = 1'b1;
    for (int i = 0; i < NUM_MSGS; i++) begin
      m1[i] = BLANK;
      m2[i] = BLANK;
    end
    #3 reset_btn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 128'(busy), 128'(1'b0));
    checkOutput("reset_refresh", 128'(refresh), 128'(1'b0));
    checkOutput("reset_idx", 128'(msg_idx), 128'(0));
    checkOutput("reset_line1", line1, BLANK);
    checkOutput("reset_line2", line2, BLANK);
    @(posedge clk); #1 reset_btn = 1'b1;

    // Static mode: one refresh, then idle after exactly DWELL dwell cycles.
    writeSlot(0, "Morse Translator", "  LCD Test OK   ");
    writeSlot(1, randLine(), randLine());
    expQ.push_back(model(0, 0));
    applyStimulus(2'd0);
    waitRefresh(40, t0);
    repeat (DWELL) @(negedge clk);
    checkOutput("static_busy_last_dwell", 128'(busy), 128'(1'b1));
    @(negedge clk);
    checkOutput("static_idle_after_dwell", 128'(busy), 128'(1'b0));
    repeat (20) @(negedge clk);
    checkOutput("static_line1_hold", line1, 128'("Morse Translator"));

    // Cycle mode, with a mode change and a write to the shown slot mid-dwell.
    expQ.push_back(model(0, 0));
    applyStimulus(2'd1);
    waitRefresh(40, t0);
    mode  = 2'd0;
    oldL1 = m1[0];
    oldL2 = m2[0];
    writeSlot(0, randLine(), randLine());
    @(negedge clk);
    checkOutput("line1_unchanged_by_write", line1, oldL1);
    checkOutput("line2_unchanged_by_write", line2, oldL2);
    expQ.push_back(model(1, 0));
    waitRefresh(40, t1);
    checkOutput("cycle_period_1", 128'(t1 - t0), 128'(DWELL + 2));
    expQ.push_back(model(0, 0));
    waitRefresh(40, t0);
    checkOutput("cycle_period_2", 128'(t0 - t1), 128'(DWELL + 2));
    expQ.push_back(model(1, 0));
    waitRefresh(40, t1);
    checkOutput("cycle_period_3", 128'(t1 - t0), 128'(DWELL + 2));
    expQ.push_back(model(0, 0));
    applyStimulus(2'd1);
    waitRefresh(40, t);

    // Reset while the refresh pulse is high.
    #1 reset_btn = 1'b0;
    #1;
    checkOutput("abort_refresh", 128'(refresh), 128'(1'b0));
    checkOutput("abort_busy", 128'(busy), 128'(1'b0));
    checkOutput("abort_idx", 128'(msg_idx), 128'(0));
    checkOutput("abort_line1", line1, BLANK);
    checkOutput("abort_line2", line2, BLANK);
    for (int i = 0; i < NUM_MSGS; i++) begin
      m1[i] = BLANK;
      m2[i] = BLANK;
    end
    @(posedge clk); #1 reset_btn = 1'b1;
    c0 = refCount;
    repeat (30) @(negedge clk);
    checkOutput("quiet_after_reset_busy", 128'(busy), 128'(1'b0));
    checkOutput("quiet_after_reset_refresh", 128'(refCount), 128'(c0));

    // Handshake hold-off, and a write racing the load of the same slot.
    lcd_ready = 1'b0;
    expQ.push_back(model(0, 0));
    applyStimulus(2'd0);
    c0 = refCount;
    repeat (50) @(negedge clk);
    checkOutput("held_off_refresh", 128'(refCount), 128'(c0));
    checkOutput("held_off_busy", 128'(busy), 128'(1'b1));
    nl1 = randLine();
    nl2 = randLine();
    @(posedge clk); #1;
    lcd_ready = 1'b1;
    wr_en     = 1'b1;
    wr_idx    = 1'b0;
    wr_line1  = nl1;
    wr_line2  = nl2;
    rise      = cyc;
    @(posedge clk); #1;
    wr_en = 1'b0;
    m1[0] = nl1;
    m2[0] = nl2;
    waitRefresh(10, t);
    checkOutput("handshake_latency", 128'(t - rise), 128'(1));
    waitIdle(40);
    expQ.push_back(model(0, 0));
    applyStimulus(2'd0);
    waitRefresh(40, t);
    waitIdle(40);

    // Scroll mode under a randomly stalling LCD controller.
    writeSlot(0, randLine(), "ABCDEFGHIJKLMNOP");
    writeSlot(1, randLine(), randLine());
    for (int off = 0; off < 16; off++) expQ.push_back(model(0, off));
    expQ.push_back(model(1, 0));
    applyStimulus(2'd2);
    waitQueueEmpty(3000, 1'b1);
    lcd_ready = 1'b1;
    checkOutput("scroll_wrap_idx", 128'(msg_idx), 128'(1));
    expQ.push_back(model(0, 0));
    applyStimulus(2'd0);
    waitQueueEmpty(100, 1'b0);
    waitIdle(40);

    // Random static runs alternating mode 0 and mode 3.
    for (int k = 0; k < 4; k++) begin
      writeSlot(0, randLine(), randLine());
      writeSlot(1, randLine(), randLine());
      expQ.push_back(model(0, 0));
      lcd_ready = 1'b0;
      applyStimulus((k % 2) != 0 ? 2'd3 : 2'd0);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1 lcd_ready = 1'b1;
      waitRefresh(20, t);
      waitIdle(40);
      c0 = refCount;
      repeat (15) @(negedge clk);
      checkOutput("static_single_refresh", 128'(refCount), 128'(c0));
    end

    checkOutput("all_frames_seen", 128'(expQ.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
